// File: rtl/cdb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : cdb_pkg                                                        |
// | Purpose : Shared defaults, entry structs and helpers for the aged        |
// |           common-data-bus arbiter/broadcaster.                           |
// | Contents: default widths, CDB_ENTRY, CDB_EARLY_TAG_ENTRY, AGE_MAX().     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package cdb_pkg;

  localparam int CDB_N_PORTS = 2;
  localparam int CDB_NUM_CH  = 6;
  localparam int CDB_AGE_W   = 3;
  localparam int CDB_TAG_W   = 6;
  localparam int CDB_DATA_W  = 32;

  // One registered broadcast slot.
  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } CDB_ENTRY;

  // One combinational wakeup slot.
  typedef struct packed {
    logic                 valid;
    logic [CDB_TAG_W-1:0] tag;
  } CDB_EARLY_TAG_ENTRY;

  // Starvation threshold for an age counter of the given width.
  function automatic int AGE_MAX(input int age_w);
    return (1 << age_w) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_age_select.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : cdb_age_select                                                 |
// | Purpose : Combinational two-class N-of-M selector. Urgent requesters are |
// |           taken first in ascending index, then the remaining requesters  |
// |           in ascending index, up to N_PORTS picks. Pick k -> port k.     |
// | Ports   : req      in  [NUM_CH]          requesting channels             |
// |           urgent   in  [NUM_CH]          channels at starvation limit    |
// |           grant    out [NUM_CH]          selected channels               |
// |           port_map out [N_PORTS][NUM_CH] one-hot channel per port        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module cdb_age_select
  import cdb_pkg::*;
#(
  parameter int N_PORTS = CDB_N_PORTS,
  parameter int NUM_CH  = CDB_NUM_CH
) (
  input  logic [NUM_CH-1:0]               req,
  input  logic [NUM_CH-1:0]               urgent,
  output logic [NUM_CH-1:0]               grant,
  output logic [N_PORTS-1:0][NUM_CH-1:0]  port_map
);

  logic [NUM_CH-1:0] w_cls;
  int                w_picks;

  always_comb begin
    grant    = '0;
    port_map = '0;
    w_cls    = '0;
    w_picks  = 0;
    // Pass 0 walks the urgent class, pass 1 the ordinary requesters.
    for (int pass = 0; pass < 2; pass++) begin
      w_cls = (pass == 0) ? (req & urgent) : (req & ~urgent);
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_cls[i] && (w_picks < N_PORTS)) begin
          grant[i] = 1'b1;
          for (int k = 0; k < N_PORTS; k++) begin
            if (w_picks == k) port_map[k][i] = 1'b1;
          end
          w_picks = w_picks + 1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cdb_age_broadcast.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : cdb_age_broadcast                                              |
// | Purpose : Aged N-port common data bus. Requests at t are granted at t+1, |
// |           the granted FU data is muxed at t+1 (early tags) and broadcast |
// |           registered at t+2. Starving channels become urgent.            |
// | Ports   : clock, reset_n (async active-low), flush (sync squash)         |
// |           req/grant            [NUM_CH]   request / registered grant     |
// |           ch_valid/tag/data    [NUM_CH]   FU result in grant cycle       |
// |           early_valid/tag      [N_PORTS]  combinational wakeup           |
// |           cdb_valid/tag/data   [N_PORTS]  registered broadcast           |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module cdb_age_broadcast
  import cdb_pkg::*;
#(
  parameter int N_PORTS = CDB_N_PORTS,
  parameter int NUM_CH  = CDB_NUM_CH,
  parameter int AGE_W   = CDB_AGE_W,
  parameter int TAG_W   = CDB_TAG_W,
  parameter int DATA_W  = CDB_DATA_W
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             flush,
  input  logic [NUM_CH-1:0]                req,
  output logic [NUM_CH-1:0]                grant,
  input  logic [NUM_CH-1:0]                ch_valid,
  input  logic [NUM_CH-1:0][TAG_W-1:0]     ch_tag,
  input  logic [NUM_CH-1:0][DATA_W-1:0]    ch_data,
  output logic [N_PORTS-1:0]               early_valid,
  output logic [N_PORTS-1:0][TAG_W-1:0]    early_tag,
  output logic [N_PORTS-1:0]               cdb_valid,
  output logic [N_PORTS-1:0][TAG_W-1:0]    cdb_tag,
  output logic [N_PORTS-1:0][DATA_W-1:0]   cdb_data
);

  localparam logic [AGE_W-1:0] C_AGE_MAX = AGE_W'(AGE_MAX(AGE_W));

  logic [NUM_CH-1:0][AGE_W-1:0]   r_age;
  logic [NUM_CH-1:0]              r_grant;
  logic [N_PORTS-1:0][NUM_CH-1:0] r_map;

  logic [NUM_CH-1:0]              w_req_eff;
  logic [NUM_CH-1:0]              w_urgent;
  logic [NUM_CH-1:0]              w_sel;
  logic [N_PORTS-1:0][NUM_CH-1:0] w_map;

  logic [N_PORTS-1:0]             w_mux_valid;
  logic [N_PORTS-1:0][TAG_W-1:0]  w_mux_tag;
  logic [N_PORTS-1:0][DATA_W-1:0] w_mux_data;

  // A flush cycle behaves as if nobody requested: no grants next cycle and
  // every age counter falls back to zero through the "req low" path.
  assign w_req_eff = flush ? '0 : req;

  always_comb begin
    w_urgent = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_urgent[i] = w_req_eff[i] && (r_age[i] == C_AGE_MAX);
    end
  end

  cdb_age_select #(
    .N_PORTS (N_PORTS),
    .NUM_CH  (NUM_CH)
  ) u_select (
    .req      (w_req_eff),
    .urgent   (w_urgent),
    .grant    (w_sel),
    .port_map (w_map)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_age   <= '0;
      r_grant <= '0;
      r_map   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_req_eff[i] && !w_sel[i]) begin
          r_age[i] <= (r_age[i] == C_AGE_MAX) ? r_age[i] : r_age[i] + 1'b1;
        end else begin
          r_age[i] <= '0;
        end
      end
      r_grant <= w_sel;
      r_map   <= w_map;
    end
  end

  // Port mux: the map is one-hot per port, so OR-reduction selects the
  // owner. Gating by ch_valid turns an invalid owner into an all-zero bubble.
  always_comb begin
    w_mux_valid = '0;
    w_mux_tag   = '0;
    w_mux_data  = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_map[k][i] && ch_valid[i]) begin
          w_mux_valid[k] = 1'b1;
          w_mux_tag[k]   = w_mux_tag[k] | ch_tag[i];
          w_mux_data[k]  = w_mux_data[k] | ch_data[i];
        end
      end
    end
  end

  assign grant       = r_grant;
  assign early_valid = w_mux_valid & {N_PORTS{~flush}};
  assign early_tag   = w_mux_tag;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cdb_valid <= '0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
    end else if (flush) begin
      cdb_valid <= '0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
    end else begin
      cdb_valid <= w_mux_valid;
      cdb_tag   <= w_mux_tag;
      cdb_data  <= w_mux_data;
    end
  end

endmodule
`default_nettype wire

// File: doc/cdb_age_broadcast.md
# cdb_age_broadcast

Parametrised successor to the fixed-priority CDB, used between the functional-unit issue registers and the physical register file, map table and EX forwarding network. Arbitrates up to `NUM_CH` FU completion requests onto `N_PORTS` broadcast ports each cycle. Adds per-channel starvation aging so that low-priority channels (e.g. MULT) are guaranteed a slot, and a synchronous `flush` that drops in-flight grants and broadcasts. Keeps the existing request/grant/data three-stage timing: grant next cycle, early tag in the data cycle, registered broadcast the cycle after.

## Interface
- `N_PORTS`, 2: number of CDB broadcast ports.
- `NUM_CH`, 6: number of FU channels; index 0 has the highest base priority.
- `AGE_W`, 3: age counter width; `AGE_MAX = 2**AGE_W-1` is the starvation threshold.
- `TAG_W`, 6: physical register tag width.
- `DATA_W`, 32: result data width.
- `clock`  in  1  single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous squash (mispredict recovery).
- `req`  in  NUM_CH  channel requests a broadcast slot.
- `grant`  out  NUM_CH  registered; channel owns a slot in the current cycle.
- `ch_valid`  in  NUM_CH  channel result valid in its data cycle.
- `ch_tag`  in  NUM_CH x TAG_W  channel destination tag.
- `ch_data`  in  NUM_CH x DATA_W  channel result.
- `early_valid`, `early_tag`  out  N_PORTS, N_PORTS x TAG_W  combinational wakeup tags.
- `cdb_valid`, `cdb_tag`, `cdb_data`  out  N_PORTS, x TAG_W, x DATA_W  registered broadcast.

## Operation
- Age: per channel, `age[i]` increments (saturating at AGE_MAX) when `req[i]` is high and the channel is not selected. It clears when the channel is selected or `req[i]` is low.
- Urgent class: channels with `req[i] && age[i]==AGE_MAX`.
- Selection, each cycle:
  - Urgent channels are picked first, in ascending index.
  - Remaining ports are filled with non-urgent requesters, in ascending index.
  - At most N_PORTS are picked. The k-th pick is assigned port k.
- Selection results (`grant` vector and port-to-channel one-hot map) are registered.
- Data mux: in the grant cycle, port k carries the `ch_valid`/`ch_tag`/`ch_data` of the channel mapped to it.
  - A port with no mapped channel is all-zero.
  - A mapped channel presenting `ch_valid=0` yields a bubble (valid=0, tag/data zero).
  - `ch_*` from unmapped channels are ignored.
- Early tags: `early_valid`/`early_tag` equal the port's muxed valid/tag combinationally (the same value as next-cycle `cdb_*`).
- One grant covers exactly one broadcast. A channel holding `req` high is re-arbitrated every cycle.
- Flush at cycle t:
  - `req` is ignored in cycle t.
  - Ages clear.
  - `early_valid` is forced 0 in cycle t.
  - `grant`, port map and `cdb_valid` are all 0 at t+1.
- Reset (asynchronous, any time): all registers clear. `grant`, `cdb_*`, `early_*` and ages read 0 while `reset_n` is low and on the first cycle after release.

## Timing
- t: `req` sampled and arbitrated (combinational).
- t+1: `grant` high; FU drives `ch_*`; `early_*` valid.
- t+2: `cdb_*` valid for one cycle.
- Throughput: N_PORTS broadcasts per cycle, sustained.
- Starvation bound: a continuously requesting channel is granted within AGE_MAX+ceil(NUM_CH/N_PORTS) cycles.
- Simultaneous urgent count greater than N_PORTS: lowest indices win. The losers stay at AGE_MAX.

## Structure
- `cdb_pkg` holds:
  - default widths;
  - the `CDB_ENTRY` struct (valid, tag, data) and `CDB_EARLY_TAG_ENTRY` (valid, tag);
  - helper function `AGE_MAX`.
- Sub-module `cdb_age_select`: purely combinational two-class N-of-M selector. It takes the request and urgent vectors and outputs the grant vector and port one-hot map.
- Age counters, registers and the mux live in the top.

## Test plan
- NUM_CH=6, N_PORTS=2, `req=6'b000111` once -> `grant=000011` at t+1; ch0 appears on port0 and ch1 on port1 in `cdb_*` at t+2; `early_tag` matches during t+1.
- `req=6'b100011` held continuously, AGE_W=3 -> ch5 is denied for 7 cycles, then granted on the 8th sampling cycle; its age returns to 0.
- Channels 3,4,5 all reach AGE_MAX together with ch0 requesting -> ports go to ch3, ch4; ch0 is denied.
- Granted channel drives `ch_valid=0` -> that port shows `cdb_valid=0`, tag 0; the other port is unaffected.
- `flush` asserted in the cycle after a grant -> `early_valid=0` in that cycle; `cdb_valid=0` and `grant=0` the next cycle; all ages zero.
- `reset_n` dropped mid-stream with both ports valid -> all outputs 0 immediately; the first grant appears 1 cycle after release plus a request.
